// File: rtl/alu_issue_unit.sv
// alu_issue_unit: non-pipelined issue stage for the 4-bit combinational ALU.
// It accepts one encoded instruction at a time and reads the operands from a
// small register file. It drives registered operands and the op select into
// the ALU, then writes the result back and strobes it downstream for a cycle.
module alu_issue_unit #(
  parameter int DATA_W = 4,
  parameter int NREGS  = 4,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [12:0]       instr,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  output logic              res_valid,
  output logic [RA_W-1:0]   res_rd,
  output logic [DATA_W-1:0] res_data,
  output logic              z_flag,
  output logic              busy,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam logic [2:0] OP_LI  = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

  state_t              state_reg, state_next;
  logic [2:0]          op_reg;
  logic [RA_W-1:0]     rd_reg;
  logic [DATA_W-1:0]   imm_reg;
  logic [DATA_W-1:0]   regs_reg [NREGS];

  // Instruction field decode of the incoming word
  logic [2:0]          in_op;
  logic [RA_W-1:0]     in_rd, in_rs1, in_rs2;
  logic [DATA_W-1:0]   in_imm;
  logic                in_is_alu;
  logic                accept;
  logic                wb_en;
  logic [DATA_W-1:0]   wb_data;

  assign in_op     = instr[12:10];
  assign in_rd     = instr[9:8];
  assign in_rs1    = instr[7:6];
  assign in_rs2    = instr[5:4];
  assign in_imm    = instr[3:0];
  assign in_is_alu = (in_op != OP_LI) && (in_op != OP_NOP);

  // Ready is held low while reset is asserted, even though state is IDLE.
  assign instr_ready = rst_n && (state_reg == IDLE);
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state_reg != IDLE);

  // Results are written at the end of ISSUE; NOP has no write-back.
  assign wb_en   = (state_reg == ISSUE) && (op_reg != OP_NOP);
  assign wb_data = (op_reg == OP_LI) ? imm_reg : alu_out;

  assign dbg_data = regs_reg[dbg_addr];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic: IDLE -> ISSUE on accept, then ISSUE -> WB -> IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latch the instruction and drive the ALU operand/select registers on accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_reg  <= OP_NOP;
      rd_reg  <= '0;
      imm_reg <= '0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_sel <= '0;
    end else if (accept) begin
      op_reg  <= in_op;
      rd_reg  <= in_rd;
      imm_reg <= in_imm;
      if (in_is_alu) begin
        alu_in1 <= regs_reg[in_rs1];
        alu_in2 <= regs_reg[in_rs2];
        alu_sel <= in_op;
      end else begin
        alu_in1 <= '0;
        alu_in2 <= '0;
        alu_sel <= '0;
      end
    end
  end

  // Register file write-back; the whole file clears on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else if (wb_en) begin
      regs_reg[rd_reg] <= wb_data;
    end
  end

  // Result reporting: one-cycle valid strobe during WB, sticky data/rd/zero flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_rd    <= '0;
      res_data  <= '0;
      z_flag    <= 1'b0;
    end else begin
      res_valid <= wb_en;
      if (wb_en) begin
        res_rd   <= rd_reg;
        res_data <= wb_data;
        z_flag   <= (wb_data == '0);
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Testbench for alu_issue_unit: directed table, hand sequences, random traffic
module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [12:0] instr = '0;
  logic [3:0] alu_in1, alu_in2, alu_out;
  logic [2:0] alu_sel;
  logic       res_valid;
  logic [1:0] res_rd;
  logic [3:0] res_data;
  logic       z_flag;
  logic       busy;
  logic [1:0] dbg_addr = '0;
  logic [3:0] dbg_data;

  int checks = 0;
  int failures = 0;

  // Reference state: register file contents and last reported result
  int m_r[4];
  int m_last_data;
  int m_last_rd;
  int m_z;

  always #5 clk = ~clk;

  alu_issue_unit #(.DATA_W(4), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel),
    .alu_out(alu_out), .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .z_flag(z_flag), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // The external combinational ALU that the unit drives
  always_comb begin
    alu_out = '0;
    case (alu_sel)
      3'd0: alu_out = alu_in1 + alu_in2;
      3'd1: alu_out = alu_in1 - alu_in2;
      3'd2: alu_out = alu_in1 & alu_in2;
      3'd3: alu_out = alu_in1 | alu_in2;
      3'd4: alu_out = alu_in1 ^ alu_in2;
      3'd5: alu_out = ~alu_in1;
      default: alu_out = '0;
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Architectural result of one instruction from plain arithmetic
  function automatic int calc(input int op, input int a, input int b, input int imm);
    case (op)
      0: return (a + b) % 16;
      1: return (a - b + 16) % 16;
      2: return a & b;
      3: return a | b;
      4: return a ^ b;
      5: return 15 - a;
      6: return imm;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_last_data = 0;
    m_last_rd = 0;
    m_z = 0;
  endtask

  // Issue one instruction and check ISSUE, WB and return-to-IDLE cycles.
  // Called at a sample point (#1 after a rising edge).
  task automatic run_instr(input int op, input int rd, input int rs1, input int rs2,
                           input int imm, input int exp_data, input int exp_z,
                           input int exp_valid);
    int n;
    int r;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) chk("ready_timeout", 0, 1);
    instr_valid = 1'b1;
    instr = {op[2:0], rd[1:0], rs1[1:0], rs2[1:0], imm[3:0]};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = 13'($urandom);
    chk("issue_ready", int'(instr_ready), 0);
    chk("issue_busy", int'(busy), 1);
    chk("issue_in1", int'(alu_in1), (op < 6) ? m_r[rs1] : 0);
    chk("issue_in2", int'(alu_in2), (op < 6) ? m_r[rs2] : 0);
    chk("issue_sel", int'(alu_sel), (op < 6) ? op : 0);
    r = calc(op, m_r[rs1], m_r[rs2], imm);
    if (op != 7) begin
      m_r[rd] = r;
      m_last_data = r;
      m_last_rd = rd;
      m_z = (r == 0) ? 1 : 0;
    end
    @(posedge clk); #1;
    chk("wb_valid", int'(res_valid), exp_valid);
    chk("wb_data", int'(res_data), exp_data);
    chk("wb_rd", int'(res_rd), m_last_rd);
    chk("wb_z", int'(z_flag), exp_z);
    chk("wb_ready", int'(instr_ready), 0);
    dbg_addr = rd[1:0];
    #1;
    chk("wb_dbg", int'(dbg_data), m_r[rd]);
    @(posedge clk); #1;
    chk("idle_valid", int'(res_valid), 0);
    chk("idle_ready", int'(instr_ready), 1);
  endtask

  task automatic check_all_regs(input string name);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk(name, int'(dbg_data), m_r[i]);
    end
  endtask

  typedef struct {
    int op; int rd; int rs1; int rs2; int imm;
    int exp_data; int exp_z; int exp_valid;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int op, rd, rs1, rs2, imm, r, d, z, v;
    int seen_valid;

    vecs[0] = '{6, 1, 0, 0, 4,  4, 0, 1};   // LI R1=0100
    vecs[1] = '{6, 2, 0, 0, 9,  9, 0, 1};   // LI R2=1001
    vecs[2] = '{0, 3, 1, 2, 0, 13, 0, 1};   // ADD R3=R1+R2 -> 1101
    vecs[3] = '{6, 0, 0, 0, 9,  9, 0, 1};   // LI R0=1001
    vecs[4] = '{0, 1, 0, 0, 0,  2, 0, 1};   // ADD R1=R0+R0 wraps to 0010
    vecs[5] = '{1, 2, 1, 1, 0,  0, 1, 1};   // SUB R2=R1-R1 -> 0, zero flag
    vecs[6] = '{6, 1, 0, 0, 6,  6, 0, 1};   // LI R1=0110
    vecs[7] = '{5, 2, 1, 3, 0,  9, 0, 1};   // NOT R2=~R1 -> 1001
    vecs[8] = '{7, 3, 2, 1, 5,  9, 0, 0};   // NOP: nothing changes

    model_reset();

    // Reset held: outputs zero, not ready
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", int'(instr_ready), 0);
    chk("rst_valid", int'(res_valid), 0);
    chk("rst_in1", int'(alu_in1), 0);
    chk("rst_in2", int'(alu_in2), 0);
    chk("rst_sel", int'(alu_sel), 0);
    chk("rst_data", int'(res_data), 0);
    chk("rst_rd", int'(res_rd), 0);
    chk("rst_z", int'(z_flag), 0);
    chk("rst_busy", int'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_ready", int'(instr_ready), 1);
    check_all_regs("post_rst_dbg");

    // Directed table
    for (int i = 0; i < 9; i++)
      run_instr(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                vecs[i].exp_data, vecs[i].exp_z, vecs[i].exp_valid);
    check_all_regs("nop_regs");

    // instr_valid held high: accepts every third cycle, changes outside IDLE ignored
    instr_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imm = k * 5 + 1;
      rd = k;
      instr = {3'b110, 2'(rd), 4'b0000, 4'(imm)};
      @(posedge clk); #1;
      chk("b2b_issue_ready", int'(instr_ready), 0);
      instr = {3'b110, 2'(rd), 4'b0000, 4'(imm + 7)};
      @(posedge clk); #1;
      m_r[rd] = imm; m_last_data = imm; m_last_rd = rd; m_z = 0;
      chk("b2b_wb_valid", int'(res_valid), 1);
      chk("b2b_wb_data", int'(res_data), imm);
      chk("b2b_wb_ready", int'(instr_ready), 0);
      instr = 13'($urandom);
      @(posedge clk); #1;
      chk("b2b_idle_ready", int'(instr_ready), 1);
      chk("b2b_idle_valid", int'(res_valid), 0);
    end
    instr_valid = 1'b0;
    check_all_regs("b2b_regs");

    // Reset during ISSUE of an ADD: instruction dropped, file cleared
    instr_valid = 1'b1;
    instr = {3'b000, 2'd3, 2'd1, 2'd2, 4'd0};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("mid_busy", int'(busy), 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("mid_rst_ready", int'(instr_ready), 0);
    chk("mid_rst_busy", int'(busy), 0);
    seen_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (res_valid) seen_valid = 1;
    end
    chk("mid_rst_no_valid", seen_valid, 0);
    check_all_regs("mid_rst_dbg");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    if (res_valid) seen_valid = 1;
    chk("mid_rel_ready", int'(instr_ready), 1);
    chk("mid_rel_no_valid", seen_valid, 0);
    chk("mid_rel_data", int'(res_data), 0);

    // Random traffic against the reference model
    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 7);
      rd = $urandom_range(0, 3);
      rs1 = $urandom_range(0, 3);
      rs2 = $urandom_range(0, 3);
      imm = $urandom_range(0, 15);
      r = calc(op, m_r[rs1], m_r[rs2], imm);
      d = (op == 7) ? m_last_data : r;
      z = (op == 7) ? m_z : ((r == 0) ? 1 : 0);
      v = (op == 7) ? 0 : 1;
      run_instr(op, rd, rs1, rs2, imm, d, z, v);
    end
    check_all_regs("rand_regs");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
